motor_driver: RTL

Dual H-bridge pin driver sitting directly downstream of the PWM generator. Takes the shared `pwm_signal` and a per-wheel mode command (coast/forward/reverse/brake) from the line-following controller via a valid/ready handshake. Drives the IN1/IN2 pins of the left and right motor bridges. Inserts a mandatory dead-time on every exit from a driving mode, so a bridge leg is never commanded high on both sides except in deliberate brake.

---
 rtl/motor_driver_pkg.sv | 30 +++
 rtl/motor_driver_if.sv | 10 +
 rtl/motor_channel.sv | 63 ++++++
 rtl/motor_driver.sv | 90 +++++++++
 4 files changed

// File: rtl/motor_driver_pkg.sv
// Shared mode encoding, wheel FSM states and dead-time bounds for the dual H-bridge driver.
package motor_driver_pkg;

  localparam logic [1:0] MODE_COAST = 2'b00;
  localparam logic [1:0] MODE_FWD   = 2'b01;
  localparam logic [1:0] MODE_REV   = 2'b10;
  localparam logic [1:0] MODE_BRAKE = 2'b11;

  // Low two bits of the four steady states match the mode encoding.
  typedef enum logic [2:0] {
    ST_COAST = 3'b000,
    ST_FWD   = 3'b001,
    ST_REV   = 3'b010,
    ST_BRAKE = 3'b011,
    ST_DEAD  = 3'b100
  } state_t;

  localparam int DEADTIME_MIN = 1;
  localparam int DEADTIME_MAX = 255;
  localparam int WDOG_W       = 22;

  function automatic state_t mode_to_state(input logic [1:0] mode);
    return state_t'({1'b0, mode});
  endfunction

  function automatic logic is_driving(input state_t st);
    return (st == ST_FWD) || (st == ST_REV);
  endfunction

endpackage

// File: rtl/motor_driver_if.sv
// Command handshake from the line-following controller: valid/ready plus per-wheel mode.
interface motor_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_left;
  logic [1:0] cmd_right;

  modport master (output cmd_valid, output cmd_left, output cmd_right, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_left, input cmd_right, output cmd_ready);
endinterface

// File: rtl/motor_channel.sv
// One wheel: mode FSM with dead-time on every exit from FWD/REV, registered bridge pins.
// Pins follow the state one cycle later; dead_next tells the top the wheel will be in DEAD.
module motor_channel
  import motor_driver_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm,
  input  logic       cmd_en,
  input  logic [1:0] cmd_mode,
  output logic       in1,
  output logic       in2,
  output logic       dead_next
);

  localparam int DT = (DEADTIME_CYCLES < DEADTIME_MIN) ? DEADTIME_MIN :
                      (DEADTIME_CYCLES > DEADTIME_MAX) ? DEADTIME_MAX : DEADTIME_CYCLES;
  localparam logic [7:0] DT_LOAD = 8'(DT - 1);

  state_t     state;
  state_t     req_st;
  logic [1:0] target;
  logic [7:0] cnt;

  assign req_st    = mode_to_state(cmd_mode);
  assign dead_next = (state == ST_DEAD) ? (cnt != 8'd0)
                                        : (cmd_en && is_driving(state) && (req_st != state));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_COAST;
      target <= MODE_COAST;
      cnt    <= 8'd0;
      in1    <= 1'b0;
      in2    <= 1'b0;
    end else begin
      case (state)
        ST_FWD:   begin in1 <= pwm;  in2 <= 1'b0; end
        ST_REV:   begin in1 <= 1'b0; in2 <= pwm;  end
        ST_BRAKE: begin in1 <= 1'b1; in2 <= 1'b1; end
        default:  begin in1 <= 1'b0; in2 <= 1'b0; end
      endcase

      if (state == ST_DEAD) begin
        // A command arriving in DEAD (watchdog coast) replaces the pending target.
        if (cnt == 8'd0) state <= mode_to_state(cmd_en ? cmd_mode : target);
        else             cnt   <= cnt - 8'd1;
        if (cmd_en) target <= cmd_mode;
      end else if (cmd_en && (req_st != state)) begin
        if (is_driving(state)) begin
          state  <= ST_DEAD;
          target <= cmd_mode;
          cnt    <= DT_LOAD;
        end else begin
          state <= req_st;
        end
      end
    end
  end

endmodule

// File: rtl/motor_driver.sv
// Dual H-bridge pin driver: handshake, cmd_ready, two wheel channels, optional watchdog (MOTOR_DRIVER_WATCHDOG_EN).
// Command to pin 2 edges (plus DEADTIME_CYCLES when leaving FWD/REV); cmd_ready low while any wheel is in DEAD.
module motor_driver
  import motor_driver_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 16,
  parameter int WDOG_CYCLES     = 3125000
) (
  input  logic           clk_3125KHz,
  input  logic           reset,
  input  logic           pwm_signal,
  motor_driver_if.slave  cmd,
  output logic           left_in1,
  output logic           left_in2,
  output logic           right_in1,
  output logic           right_in2,
  output logic           wdog_tripped
);

  logic       ready_q;
  logic       accept;
  logic       wdog_fire;
  logic       ch_en;
  logic [1:0] mode_l;
  logic [1:0] mode_r;
  logic       dead_next_l;
  logic       dead_next_r;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid && ready_q;
  assign ch_en         = accept || wdog_fire;
  assign mode_l        = accept ? cmd.cmd_left  : MODE_COAST;
  assign mode_r        = accept ? cmd.cmd_right : MODE_COAST;

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= !(dead_next_l || dead_next_r);
  end

`ifdef MOTOR_DRIVER_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Acceptance on the expiry edge suppresses the internal coast.
  assign wdog_fire = !accept && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      wdog_cnt     <= '0;
      wdog_tripped <= 1'b0;
    end else if (accept) begin
      wdog_cnt     <= '0;
      wdog_tripped <= 1'b0;
    end else if (wdog_fire) begin
      wdog_cnt     <= '0;
      wdog_tripped <= 1'b1;
    end else begin
      wdog_cnt     <= wdog_cnt + 1'b1;
    end
  end
`else
  assign wdog_fire    = 1'b0;
  // Period parameter is kept so both builds share one parameter list.
  assign wdog_tripped = 1'b0 & (WDOG_CYCLES != 0);
`endif

  motor_channel #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_left (
    .clk       (clk_3125KHz),
    .rst       (reset),
    .pwm       (pwm_signal),
    .cmd_en    (ch_en),
    .cmd_mode  (mode_l),
    .in1       (left_in1),
    .in2       (left_in2),
    .dead_next (dead_next_l)
  );

  motor_channel #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_right (
    .clk       (clk_3125KHz),
    .rst       (reset),
    .pwm       (pwm_signal),
    .cmd_en    (ch_en),
    .cmd_mode  (mode_r),
    .in1       (right_in1),
    .in2       (right_in2),
    .dead_next (dead_next_r)
  );

endmodule
